// File: rtl/onebit_program_loader.sv
// onebit_program_loader
//   Front-end controller for the 1-bit processor core. Buffers host instruction
//   words in a small FIFO, pulses the core reset, shifts each word into the
//   core one bit per clock over en/inReg[0], then hands the core to run mode.
//
//   Build option: define ONEBIT_LOADER_LSB_FIRST_EN to shift bit 0 of each word
//   first. By default (undefined) bit WORD_W-1 goes first.
//
// Ports
//   clk          : clock, rising edge
//   reset        : asynchronous active-low reset
//   start        : begin a load sequence (sampled only in IDLE)
//   stop         : abort load / leave run mode, back to IDLE
//   wr_valid     : host word valid
//   wr_data      : host instruction word
//   wr_ready     : loader accepts a word this cycle
//   run_in       : core input bits forwarded during RUN
//   proc_reset   : active-high core reset
//   proc_en      : core enable
//   proc_in      : core inReg
//   busy         : in RST or LOAD
//   running      : in RUN
//   done         : one-cycle pulse on entering RUN
//   words_loaded : words completely shifted into the core
module onebit_program_loader #(
    parameter int unsigned WORD_W     = 13,
    parameter int unsigned NUM_WORDS  = 4,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               stop,
    input  logic                               wr_valid,
    input  logic [WORD_W-1:0]                  wr_data,
    output logic                               wr_ready,
    input  logic [1:0]                         run_in,
    output logic                               proc_reset,
    output logic                               proc_en,
    output logic [1:0]                         proc_in,
    output logic                               busy,
    output logic                               running,
    output logic                               done,
    output logic [$clog2(NUM_WORDS+1)-1:0]     words_loaded
);

    localparam int unsigned WL_W  = $clog2(NUM_WORDS + 1);
    localparam int unsigned BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RST  = 2'd1,
        S_LOAD = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WL_W-1:0]   acc_q, acc_d;
    logic [WL_W-1:0]   words_loaded_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [WORD_W-1:0] mem [FIFO_DEPTH];

    logic              wr_ready_d;
    logic              proc_reset_d;
    logic              proc_en_d;
    logic [1:0]        proc_in_d;
    logic              busy_d;
    logic              running_d;
    logic              done_d;

    logic              push_c;
    logic              pop_c;
    logic              flush_c;
    logic [WORD_W-1:0] head_c;
    logic [BIT_W-1:0]  bit_idx_c;
    logic              head_bit_c;

    // Bit of the FIFO head selected by the serializer position
    assign head_c = mem[rd_ptr_q];
`ifdef ONEBIT_LOADER_LSB_FIRST_EN
    assign bit_idx_c = bit_cnt_q;
`else
    assign bit_idx_c = BIT_W'(WORD_W - 1) - bit_cnt_q;
`endif
    assign head_bit_c = head_c[bit_idx_c];

    // Next-state, FIFO bookkeeping and next values of the registered outputs
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        acc_d          = acc_q;
        words_loaded_d = words_loaded;
        flush_c        = 1'b0;
        pop_c          = 1'b0;
        proc_reset_d   = 1'b0;
        proc_en_d      = 1'b0;
        proc_in_d      = 2'b00;
        done_d         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // stop has priority over start
                if (!stop && start) begin
                    state_d        = S_RST;
                    flush_c        = 1'b1;
                    bit_cnt_d      = '0;
                    acc_d          = '0;
                    words_loaded_d = '0;
                    proc_reset_d   = 1'b1;
                end
            end
            S_RST: begin
                if (stop) begin
                    state_d   = S_IDLE;
                    flush_c   = 1'b1;
                    bit_cnt_d = '0;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (stop) begin
                    state_d   = S_IDLE;
                    flush_c   = 1'b1;
                    bit_cnt_d = '0;
                end else if (words_loaded == WL_W'(NUM_WORDS)) begin
                    state_d   = S_RUN;
                    done_d    = 1'b1;
                    proc_en_d = 1'b1;
                    proc_in_d = run_in;
                end else if (count_q != '0) begin
                    // Head is always a whole word, so shifting never stalls mid-word
                    proc_en_d = 1'b1;
                    proc_in_d = {1'b0, head_bit_c};
                    if (bit_cnt_q == BIT_W'(WORD_W - 1)) begin
                        pop_c          = 1'b1;
                        bit_cnt_d      = '0;
                        words_loaded_d = words_loaded + WL_W'(1);
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else begin
                    proc_en_d = 1'b1;
                    proc_in_d = run_in;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        push_c = wr_valid && wr_ready && !flush_c;
        if (push_c) begin
            acc_d = acc_d + WL_W'(1);
        end

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_c) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        busy_d     = (state_d == S_RST) || (state_d == S_LOAD);
        running_d  = (state_d == S_RUN);
        wr_ready_d = busy_d && (count_d < CNT_W'(FIFO_DEPTH))
                     && (acc_d < WL_W'(NUM_WORDS));
    end

    // State, control and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            acc_q        <= '0;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            words_loaded <= '0;
            wr_ready     <= 1'b0;
            proc_reset   <= 1'b0;
            proc_en      <= 1'b0;
            proc_in      <= 2'b00;
            busy         <= 1'b0;
            running      <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            words_loaded <= words_loaded_d;
            wr_ready     <= wr_ready_d;
            proc_reset   <= proc_reset_d;
            proc_en      <= proc_en_d;
            proc_in      <= proc_in_d;
            busy         <= busy_d;
            running      <= running_d;
            done         <= done_d;
        end
    end

    // Word storage; validity is tracked by count_q, so no reset needed
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_onebit_program_loader.sv
// Testbench for onebit_program_loader: program loads driven from a table of
// word sets, plus directed sequences for run mode, stop and async reset.
module tb_onebit_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        wr_valid = 1'b0;
    logic [12:0] wr_data = '0;
    logic        wr_ready;
    logic [1:0]  run_in = 2'b00;
    logic        proc_reset;
    logic        proc_en;
    logic [1:0]  proc_in;
    logic        busy;
    logic        running;
    logic        done;
    logic [2:0]  words_loaded;

    onebit_program_loader #(
        .WORD_W     (13),
        .NUM_WORDS  (4),
        .FIFO_DEPTH (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .run_in       (run_in),
        .proc_reset   (proc_reset),
        .proc_en      (proc_en),
        .proc_in      (proc_in),
        .busy         (busy),
        .running      (running),
        .done         (done),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Observations collected by run_load
    logic got[$];
    int   bubbles;
    int   first_gap_pos;
    int   reset_pulses;
    int   done_pulses;
    int   extra_accepts;
    int   in1_errs;
    int   idle_in_errs;
    logic run_at_done;
    logic en_at_done;
    logic prev_en_at_done;
    logic [2:0] wl_at_done;

    // Start a load and act as host + core observer until done, abort point or budget
    task automatic run_load(input logic [3:0][12:0] words, input int gap, input bit offer_extra,
                            input logic [12:0] extra_word, input int abort_at);
        int   widx;
        int   wait_cnt;
        int   cyc;
        bit   offer;
        logic last_en;
        widx = 0; wait_cnt = 0; cyc = 0; last_en = 1'b0;
        got.delete();
        bubbles = 0; first_gap_pos = -1; reset_pulses = 0; done_pulses = 0;
        extra_accepts = 0; in1_errs = 0; idle_in_errs = 0;
        run_at_done = 1'b0; en_at_done = 1'b0; prev_en_at_done = 1'b0; wl_at_done = '0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < 300) begin
            if (proc_reset) reset_pulses++;
            if (done) begin
                done_pulses++;
                run_at_done     = running;
                en_at_done      = proc_en;
                prev_en_at_done = last_en;
                wl_at_done      = words_loaded;
                break;
            end
            if (busy && proc_en) begin
                got.push_back(proc_in[0]);
                if (proc_in[1]) in1_errs++;
                last_en = 1'b1;
            end else if (busy) begin
                if (got.size() > 0) begin
                    bubbles++;
                    if (first_gap_pos < 0) first_gap_pos = got.size();
                end
                if (proc_in != 2'b00) idle_in_errs++;
                last_en = 1'b0;
            end
            if (abort_at >= 0 && got.size() == abort_at) break;
            offer = 1'b0;
            if (widx < 4) begin
                if (widx == 1 && gap > 0) begin
                    if (got.size() >= 13) begin
                        if (wait_cnt >= gap - 1) offer = 1'b1;
                        else wait_cnt++;
                    end
                end else begin
                    offer = 1'b1;
                end
                wr_valid = offer;
                wr_data  = words[widx];
                if (offer && wr_ready) widx++;
            end else if (offer_extra) begin
                wr_valid = 1'b1;
                wr_data  = extra_word;
                if (wr_ready) extra_accepts++;
            end else begin
                wr_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        wr_valid = 1'b0;
    endtask

    // Count serialized bits that differ from the expected shift order
    function automatic int bit_errors(input logic [3:0][12:0] words);
        int errs;
        int idx;
        int j;
        errs = 0;
        j = 0;
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < 13; k++) begin
`ifdef ONEBIT_LOADER_LSB_FIRST_EN
                idx = k;
`else
                idx = 12 - k;
`endif
                if (j >= got.size() || got[j] !== words[w][idx]) errs++;
                j++;
            end
        end
        return errs;
    endfunction

    typedef struct {
        logic [3:0][12:0] words;       // words[0] is sent first
        int               gap;         // host delay before word 1 (0 = none)
        bit               extra;       // offer a fifth word
        int               exp_bubbles;
        int               exp_gap_pos;
    } prog_t;

    typedef struct {
        logic       start;
        logic [1:0] run_in;
        logic [1:0] exp_proc_in;
    } run_vec_t;

    prog_t    progs[3];
    run_vec_t rvecs[4];

    task automatic stop_and_check(input string tag);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check({tag, "_stop_en"}, proc_en, 1'b0);
        check({tag, "_stop_busy"}, busy, 1'b0);
        check({tag, "_stop_running"}, running, 1'b0);
    endtask

    logic [12:0] first13;

    initial begin
        progs[0] = '{words: {13'h0AAA, 13'h1555, 13'h0000, 13'h1FFF}, gap: 0, extra: 1'b1,
                     exp_bubbles: 0, exp_gap_pos: -1};
        progs[1] = '{words: {13'h0AAA, 13'h1555, 13'h0000, 13'h1FFF}, gap: 7, extra: 1'b0,
                     exp_bubbles: 7, exp_gap_pos: 13};
        progs[2] = '{words: {13'h1800, 13'h0F0F, 13'h1234, 13'h0001}, gap: 0, extra: 1'b1,
                     exp_bubbles: 0, exp_gap_pos: -1};
        rvecs[0] = '{start: 1'b0, run_in: 2'b10, exp_proc_in: 2'b10};
        rvecs[1] = '{start: 1'b1, run_in: 2'b01, exp_proc_in: 2'b01};
        rvecs[2] = '{start: 1'b0, run_in: 2'b11, exp_proc_in: 2'b11};
        rvecs[3] = '{start: 1'b0, run_in: 2'b00, exp_proc_in: 2'b00};

        // Power-on reset
        #2;
        check("por_busy", busy, 1'b0);
        check("por_proc_en", proc_en, 1'b0);
        check("por_wr_ready", wr_ready, 1'b0);
        check("por_words_loaded", words_loaded, 3'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 1'b0);
        check("idle_wr_ready", wr_ready, 1'b0);

        // Table-driven program loads
        for (int p = 0; p < 3; p++) begin
            run_load(progs[p].words, progs[p].gap, progs[p].extra, 13'h1ABC, -1);
            check($sformatf("p%0d_reset_pulses", p), reset_pulses, 1);
            check($sformatf("p%0d_bit_count", p), got.size(), 52);
            check($sformatf("p%0d_bit_errors", p), bit_errors(progs[p].words), 0);
            check($sformatf("p%0d_in1_errs", p), in1_errs, 0);
            check($sformatf("p%0d_idle_in_errs", p), idle_in_errs, 0);
            check($sformatf("p%0d_bubbles", p), bubbles, progs[p].exp_bubbles);
            check($sformatf("p%0d_gap_pos", p), first_gap_pos, progs[p].exp_gap_pos);
            check($sformatf("p%0d_done_seen", p), done_pulses, 1);
            check($sformatf("p%0d_done_after_last_bit", p), prev_en_at_done, 1'b1);
            check($sformatf("p%0d_running_at_done", p), run_at_done, 1'b1);
            check($sformatf("p%0d_en_at_done", p), en_at_done, 1'b1);
            check($sformatf("p%0d_words_loaded", p), wl_at_done, 3'd4);
            if (progs[p].extra) check($sformatf("p%0d_extra_accepts", p), extra_accepts, 0);
            if (p == 2) begin
                first13 = '0;
                for (int k = 0; k < 13 && k < got.size(); k++) first13 = {first13[11:0], got[k]};
`ifdef ONEBIT_LOADER_LSB_FIRST_EN
                check("p2_word0_order", first13, 13'h1000);
`else
                check("p2_word0_order", first13, 13'h0001);
`endif
            end
            @(negedge clk);
            check($sformatf("p%0d_done_pulse_end", p), done, 1'b0);
            check($sformatf("p%0d_still_running", p), running, 1'b1);
            stop_and_check($sformatf("p%0d", p));
        end

        // Run mode: run_in forwarded one cycle later, start ignored
        run_load(progs[0].words, 0, 1'b0, 13'h0, -1);
        check("run_entry_done", done_pulses, 1);
        for (int v = 0; v < 4; v++) begin
            start  = rvecs[v].start;
            run_in = rvecs[v].run_in;
            @(negedge clk);
            start = 1'b0;
            check($sformatf("run%0d_proc_in", v), proc_in, rvecs[v].exp_proc_in);
            check($sformatf("run%0d_proc_en", v), proc_en, 1'b1);
            check($sformatf("run%0d_running", v), running, 1'b1);
            check($sformatf("run%0d_busy", v), busy, 1'b0);
            check($sformatf("run%0d_proc_reset", v), proc_reset, 1'b0);
        end
        run_in = 2'b11;
        stop_and_check("run");
        check("run_stop_proc_in", proc_in, 2'b00);
        run_in = 2'b00;

        // start and stop together in IDLE: stay idle
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check("startstop_busy", busy, 1'b0);
        check("startstop_proc_reset", proc_reset, 1'b0);
        @(negedge clk);
        check("startstop_busy2", busy, 1'b0);

        // stop mid-load: words_loaded kept, FIFO flushed for the next load
        run_load(progs[2].words, 0, 1'b0, 13'h0, 20);
        check("abort_wl_before", words_loaded, 3'd1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("abort_en", proc_en, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_wr_ready", wr_ready, 1'b0);
        check("abort_wl_kept", words_loaded, 3'd1);
        run_load(progs[0].words, 0, 1'b0, 13'h0, -1);
        check("reload_bits", bit_errors(progs[0].words), 0);
        check("reload_count", got.size(), 52);
        check("reload_wl", wl_at_done, 3'd4);
        stop_and_check("reload");

        // Async reset in the middle of word 2
        run_load(progs[0].words, 0, 1'b0, 13'h0, 32);
        check("mid_busy", busy, 1'b1);
        check("mid_wl", words_loaded, 3'd2);
        reset = 1'b0;
        #1;
        check("areset_busy", busy, 1'b0);
        check("areset_proc_en", proc_en, 1'b0);
        check("areset_proc_in", proc_in, 2'b00);
        check("areset_wr_ready", wr_ready, 1'b0);
        check("areset_wl", words_loaded, 3'd0);
        check("areset_running", running, 1'b0);
        check("areset_proc_reset", proc_reset, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_busy", busy, 1'b0);
        check("post_reset_wr_ready", wr_ready, 1'b0);
        check("post_reset_wl", words_loaded, 3'd0);
        check("post_reset_proc_en", proc_en, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/onebit_program_loader.md
# onebit_program_loader

Front-end controller for the 1-bit processor core. It accepts 13-bit instruction words from a host over a valid/ready interface and buffers them in a small FIFO. It resets the core, serializes the words into the core's instruction memory one bit per clock through the core's `en`/`inReg[0]` load path, then hands the core over to run mode. It sits between the host/test harness and the core's `clk`/`reset`/`en`/`inReg` pins.

## Interface
- `WORD_W`, 13, instruction word width in bits.
- `NUM_WORDS`, 4, words per program; load ends after this many.
- `FIFO_DEPTH`, 2, host-side word buffer depth (power of two, ≥2).

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `start` in 1: begin load sequence; sampled only in IDLE.
- `stop` in 1: abort load or leave run mode; returns to IDLE.
- `wr_valid` in 1: host word valid.
- `wr_data` in WORD_W: host instruction word.
- `wr_ready` out 1: loader accepts word this cycle.
- `run_in` in 2: core input bits used during RUN.
- `proc_reset` out 1: active-high reset to core.
- `proc_en` out 1: core enable.
- `proc_in` out 2: core `inReg`.
- `busy` out 1: state is RST or LOAD.
- `running` out 1: state is RUN.
- `done` out 1: one-cycle pulse on entering RUN.
- `words_loaded` out clog2(NUM_WORDS+1): words fully shifted into core.

## Operation
- All outputs registered; reset values: every output 0, FIFO empty, state IDLE.
- States:
  - IDLE: `start`=1 → RST.
  - RST: `proc_reset`=1 for exactly one cycle → LOAD.
  - LOAD: after `NUM_WORDS` words are shifted → RUN.
  - RUN: `stop`=1 → IDLE.
  - `stop` in RST/LOAD → IDLE; FIFO flushed; `words_loaded` kept until next `start`.
  - `start` in any non-IDLE state is ignored.
  - `stop` and `start` both high in IDLE: `stop` wins, remain IDLE.
- Word accept:
  - `wr_ready` = (state RST or LOAD) and FIFO not full and words accepted < `NUM_WORDS`.
  - Transfer on `wr_valid & wr_ready`.
  - Excess words are never accepted.
- Serializer (LOAD):
  - While the FIFO head is valid, it emits one bit per cycle with `proc_en`=1, `proc_in[0]`=bit, `proc_in[1]`=0; MSB first by default.
  - Bit counter runs 0..WORD_W-1. At WORD_W-1 it pops the head, increments `words_loaded` and wraps to 0.
  - FIFO empty at a word boundary: `proc_en`=0, `proc_in`=0 (core holds) until the next word arrives. There is never a stall mid-word, because a word is only started once it is whole in the FIFO.
- RUN: `proc_en`=1, `proc_in`=`run_in` delayed one register stage, `running`=1.
- IDLE: `proc_en`=0, `proc_in`=0.

## Timing
- `start` sampled at edge T: `busy`=1 and `proc_reset`=1 during cycle T+1; LOAD from T+2.
- Word resident in FIFO at LOAD edge E: first bit on `proc_in[0]` in cycle E+1.
- Consecutive buffered words shift with zero bubble cycles; a full program takes exactly `NUM_WORDS`·`WORD_W` `proc_en` cycles.
- Last bit of the final word is on `proc_in[0]` in cycle L: `done`=1, `running`=1 and RUN outputs start in cycle L+1.
- `stop` at edge S: `proc_en`=0 from cycle S+1.
- Async `reset` low: all outputs 0 immediately, regardless of state. Load progress is discarded; the host must re-`start`.

## Configuration
- `ONEBIT_LOADER_LSB_FIRST_EN`:
  - Defined: each word serializes bit 0 first.
  - Undefined (default): bit WORD_W-1 first.
  - Nothing else changes.

## Test plan
- Reset: `reset`=0 mid-LOAD (bit 5 of word 2) → all outputs 0 immediately. After release, IDLE with `wr_ready`=0 and `words_loaded`=0.
- Full load, back-to-back: `start`, then host streams 13'h1FFF, 13'h0000, 13'h1555, 13'h0AAA with `wr_valid` held → `proc_reset` pulse of 1 cycle. Then 52 contiguous `proc_en` cycles carrying those bits MSB first, then `done` pulse, `words_loaded`=4.
- Host stall: second word delayed 7 cycles → `proc_en`=0 for exactly 7 cycles between words; bit sequence unchanged.
- Overflow: host offers a 5th word → `wr_ready` stays 0; the word is never shifted.
- Run and stop: in RUN, `run_in`=2'b10 → `proc_in`=2'b10 one cycle later with `proc_en`=1. `stop` → `proc_en`=0 the next cycle and state IDLE. A `start` while in RUN is ignored.
- With `ONEBIT_LOADER_LSB_FIRST_EN` defined: word 13'h0001 → `proc_in[0]` sequence 1 then twelve 0s.
